// File: rtl/inv_fact_pkg.sv
// Shared types for the inverse-factorial unit: FSM state encoding and default width.
package inv_fact_pkg;

  localparam int unsigned DefaultSize = 8;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StInit = 3'd1,
    StCmp  = 3'd2,
    StMul  = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/inv_fact_dp.sv
// Multiply-compare datapath: holds the target, running product, index and overflow flag.
module inv_fact_dp
  import inv_fact_pkg::*;
#(
  parameter int unsigned SIZE = DefaultSize
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            init,
  input  logic            step,
  input  logic [SIZE-1:0] value,
  output logic [SIZE-1:0] k,
  output logic            ovf,
  output logic            gt,
  output logic            eq
);

  logic [SIZE-1:0]   tgt_q;
  logic [SIZE-1:0]   prod_q;
  logic [SIZE-1:0]   k_q;
  logic              ovf_q;
  logic [SIZE-1:0]   k_inc;
  logic [2*SIZE-1:0] wide;

  assign k_inc = k_q + SIZE'(1);
  assign wide  = {{SIZE{1'b0}}, prod_q} * {{SIZE{1'b0}}, k_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q  <= '0;
      prod_q <= '0;
      k_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (load) begin
        tgt_q <= value;
      end
      if (init) begin
        prod_q <= SIZE'(1);
        k_q    <= SIZE'(1);
        ovf_q  <= 1'b0;
      end else if (step) begin
        // Overflow is sticky so the next compare terminates the run.
        prod_q <= wide[SIZE-1:0];
        k_q    <= k_inc;
        if (wide[2*SIZE-1:SIZE] != '0) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign k   = k_q;
  assign ovf = ovf_q;
  assign gt  = prod_q > tgt_q;
  assign eq  = prod_q == tgt_q;

endmodule

// File: rtl/inv_factorial.sv
// Inverse-factorial unit: FSM finding the largest n with n! <= value.
// Define INV_FACT_DEBUG_EN to expose the FSM state on curr_state.
module inv_factorial
  import inv_fact_pkg::*;
#(
  parameter int unsigned SIZE = DefaultSize
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [SIZE-1:0] value,
  output logic            done,
  output logic            exact,
  output logic [SIZE-1:0] n_out
`ifdef INV_FACT_DEBUG_EN
  ,
  output logic [2:0]      curr_state
`endif
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] n_out_q, n_out_d;
  logic            exact_q, exact_d;
  logic            dp_load, dp_init, dp_step;
  logic [SIZE-1:0] k;
  logic            ovf, gt, eq;

  inv_fact_dp #(
    .SIZE (SIZE)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .load  (dp_load),
    .init  (dp_init),
    .step  (dp_step),
    .value (value),
    .k     (k),
    .ovf   (ovf),
    .gt    (gt),
    .eq    (eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      n_out_q <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_out_q <= n_out_d;
      exact_q <= exact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_out_d = n_out_q;
    exact_d = exact_q;
    dp_load = 1'b0;
    dp_init = 1'b0;
    dp_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          dp_load = 1'b1;
          n_out_d = '0;
          exact_d = 1'b0;
          state_d = StInit;
        end
      end
      StInit: begin
        dp_init = 1'b1;
        state_d = StCmp;
      end
      StCmp: begin
        if (ovf || gt) begin
          n_out_d = k - SIZE'(1);
          exact_d = 1'b0;
          state_d = StDone;
        end else if (eq) begin
          n_out_d = k;
          exact_d = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StMul;
        end
      end
      StMul: begin
        dp_step = 1'b1;
        state_d = StCmp;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Done is a decode of the registered state, so it is glitch-free and input-independent.
  assign done  = (state_q == StDone);
  assign exact = exact_q;
  assign n_out = n_out_q;

`ifdef INV_FACT_DEBUG_EN
  assign curr_state = state_q;
`endif

endmodule
